// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
//   LSB first, through a single full-subtractor cell and a borrow flop.
//   A start/busy/done handshake lets a controlling FSM sequence operations.
//
// Parameters
//   WIDTH       operand/result width in bits (2..32)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (priority over everything)
//   start       request; sampled only while busy==0 (IDLE or DONE)
//   a, b        minuend / subtrahend, latched when start is accepted
//   busy        high while the operation is running (WIDTH cycles)
//   done        one-cycle pulse: result outputs are valid
//   diff        a - b modulo 2^WIDTH
//   borrow_out  unsigned borrow (a < b)
//   ovf         signed overflow of a - b
//   zero        diff == 0
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;        // minuend shift register, LSB consumed first
  logic [WIDTH-1:0] sb;        // subtrahend shift register
  logic [WIDTH-1:0] res;       // result shift register, filled from the MSB end
  logic [CW-1:0]    cnt;       // index of the bit processed at the next edge
  logic             br;        // running borrow
  logic             a_msb;     // operand sign bits kept for the overflow test,
  logic             b_msb;     // since the shift registers lose them

  // Full-subtractor cell for the current bit.
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_next = {d, res[WIDTH-1:1]};
  end

  // NOTE: every register below is assigned with <= so all flops update from
  // the same pre-edge values; a blocking = here would chain them within a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          // Last bit: publish all results at once so no partial value is
          // ever visible on the outputs.
          if (cnt == CW'(WIDTH - 1)) begin
            diff       <= res_next;
            borrow_out <= br_next;
            ovf        <= (a_msb ^ b_msb) & (a_msb ^ d);
            zero       <= (res_next == '0);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed checks of serial_subtractor at WIDTH=8 plus an exhaustive sweep
//   of a WIDTH=4 instance against an arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8, ovf8, zero8;
  logic [7:0] diff8;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
    .borrow_out(borrow8), .ovf(ovf8), .zero(zero8)
  );

  // WIDTH=4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4, ovf4, zero4;
  logic [3:0] diff4;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4),
    .borrow_out(borrow4), .ovf(ovf4), .zero(zero4)
  );

  int passed = 0;
  int total  = 0;

  // Launch one W=8 operation and wait (bounded) for done.
  // lat = number of rising edges after the accepting edge until done is seen.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output logic got_done);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    got_done = done8;
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv,
                      output logic got_done);
    int n;
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    got_done = done4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy8, done8, diff8, borrow8, ovf8, zero8} !== 13'b0)
      $display("FAIL reset8: got busy=%b done=%b diff=%h bo=%b ovf=%b z=%b, want all 0",
               busy8, done8, diff8, borrow8, ovf8, zero8);
    else passed++;
    total++;
    if ({busy4, done4, diff4, borrow4, ovf4, zero4} !== 9'b0)
      $display("FAIL reset4: got busy=%b done=%b diff=%h, want all 0", busy4, done4, diff4);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic gd;
    // 5 - 3
    run8(8'h05, 8'h03, lat, gd);
    total++;
    if (!gd || lat != 8) $display("FAIL latency: got done=%b after %0d edges, want done after 8", gd, lat);
    else passed++;
    total++;
    if ({diff8, borrow8, ovf8, zero8} !== {8'h02, 3'b000})
      $display("FAIL sub_5_3: got diff=%h bo=%b ovf=%b z=%b, want 02 0 0 0", diff8, borrow8, ovf8, zero8);
    else passed++;
    total++;
    if (busy8 !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busy8);
    else passed++;
    // done is a one-cycle pulse
    @(negedge clk);
    total++;
    if (done8 !== 1'b0) $display("FAIL done_pulse: got done=%b one cycle later, want 0", done8);
    else passed++;
    // 3 - 5
    run8(8'h03, 8'h05, lat, gd);
    total++;
    if (!gd || {diff8, borrow8, ovf8, zero8} !== {8'hFE, 3'b100})
      $display("FAIL sub_3_5: got done=%b diff=%h bo=%b ovf=%b z=%b, want FE 1 0 0", gd, diff8, borrow8, ovf8, zero8);
    else passed++;
    // 0x80 - 0x01: signed overflow
    run8(8'h80, 8'h01, lat, gd);
    total++;
    if (!gd || {diff8, borrow8, ovf8, zero8} !== {8'h7F, 3'b010})
      $display("FAIL sub_80_01: got done=%b diff=%h bo=%b ovf=%b z=%b, want 7F 0 1 0", gd, diff8, borrow8, ovf8, zero8);
    else passed++;
    // 0x7F - 0xFF = 0x80 (127 - (-1) overflows), unsigned borrow set
    run8(8'h7F, 8'hFF, lat, gd);
    total++;
    if (!gd || {diff8, borrow8, ovf8, zero8} !== {8'h80, 3'b110})
      $display("FAIL sub_7F_FF: got done=%b diff=%h bo=%b ovf=%b z=%b, want 80 1 1 0", gd, diff8, borrow8, ovf8, zero8);
    else passed++;
  endtask

  task automatic test_zero_ignore();
    int lat; logic gd; int dones;
    run8(8'h55, 8'h55, lat, gd);
    total++;
    if (!gd || {diff8, borrow8, ovf8, zero8} !== {8'h00, 3'b001})
      $display("FAIL sub_55_55: got done=%b diff=%h bo=%b ovf=%b z=%b, want 00 0 0 1", gd, diff8, borrow8, ovf8, zero8);
    else passed++;
    // 0x10 - 0x01, then disturb a/b and pulse start while busy
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
    @(negedge clk);
    start8 = 1'b1;
    total++;
    if (busy8 !== 1'b1 || diff8 !== 8'h00)
      $display("FAIL hold_in_run: got busy=%b diff=%h, want busy=1 diff=00", busy8, diff8);
    else passed++;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done8) dones++;
    end
    total++;
    if (dones != 1 || diff8 !== 8'h0F || borrow8 !== 1'b0)
      $display("FAIL ignore_start: got %0d dones diff=%h bo=%b, want 1 done diff=0F bo=0", dones, diff8, borrow8);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    a8 = 8'h09; b8 = 8'h04; start8 = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done8) begin
        if (first < 0) first = n;
        else if (second < 0) begin
          second = n;
          total++;
          if (diff8 !== 8'h05 || busy8 !== 1'b0)
            $display("FAIL b2b_result: got diff=%h busy=%b, want 05 0", diff8, busy8);
          else passed++;
        end
      end
    end
    start8 = 1'b0;
    total++;
    if (first < 0 || second - first != 9)
      $display("FAIL b2b_spacing: got done at %0d and %0d, want 9 cycles apart", first, second);
    else passed++;
    repeat (12) @(negedge clk);
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    int dones;
    // Leave a nonzero result on the outputs first.
    @(negedge clk);
    a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);              // RUN cycle 1
    start8 = 1'b0;
    repeat (3) @(negedge clk);   // RUN cycle 4
    total++;
    if (busy8 !== 1'b1 || diff8 !== 8'h05)
      $display("FAIL pre_reset: got busy=%b diff=%h, want busy=1 diff=05", busy8, diff8);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy8, done8, diff8, borrow8, ovf8, zero8} !== 13'b0)
      $display("FAIL reset_midrun: got busy=%b done=%b diff=%h bo=%b ovf=%b z=%b, want all 0",
               busy8, done8, diff8, borrow8, ovf8, zero8);
    else passed++;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    total++;
    if (dones != 0) $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", dones);
    else passed++;
  endtask

  task automatic test_exhaustive4();
    logic gd;
    int   ia, ib, sd;
    logic [3:0] exp_d;
    logic exp_bo, exp_ovf, exp_z;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run4(4'(i), 4'(j), gd);
        ia      = (i >= 8) ? i - 16 : i;
        ib      = (j >= 8) ? j - 16 : j;
        sd      = ia - ib;
        exp_d   = 4'((i - j) & 15);
        exp_bo  = (i < j);
        exp_ovf = (sd > 7) || (sd < -8);
        exp_z   = (exp_d == 4'd0);
        total++;
        if (!gd || {diff4, borrow4, ovf4, zero4} !== {exp_d, exp_bo, exp_ovf, exp_z})
          $display("FAIL w4_%0d_%0d: got done=%b diff=%h bo=%b ovf=%b z=%b, want %h %b %b %b",
                   i, j, gd, diff4, borrow4, ovf4, zero4, exp_d, exp_bo, exp_ovf, exp_z);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_ignore();
    test_back_to_back();
    test_reset_midrun();
    test_exhaustive4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
